// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/branch controller for the PC datapath. Each instruction
//            spends at least one FETCH cycle and then exactly one EXEC cycle.
//            The block drives PCsrc/ImmOp so the PC holds, advances by 4, or
//            takes a BEQ/BNE branch. It also latches the fetched instruction
//            and keeps saturating retire and stall counters.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            halt                - freezes fetch (sampled in FETCH only)
//            imem_ready, instr   - instruction memory handshake and data
//            eq                  - ALU equal flag, used during EXEC
//            imem_req            - fetch request for the current PC
//            PCsrc, ImmOp        - datapath next-PC select and offset
//            instr_q/instr_valid - latched instruction, executing this cycle
//            retire_cnt          - instructions executed (saturating)
//            stall_cnt           - memory wait cycles (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int WIDTH = 32,   // must be >= 32: the full RV32 word is decoded
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] instr,
  input  logic             eq,
  output logic             imem_req,
  output logic             PCsrc,
  output logic [WIDTH-1:0] ImmOp,
  output logic [WIDTH-1:0] instr_q,
  output logic             instr_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [2:0] c_f3_beq     = 3'b000;
  localparam logic [2:0] c_f3_bne     = 3'b001;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] instr_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Branch decode of the latched instruction.
  logic        w_is_branch;
  logic [2:0]  w_funct3;
  logic        w_taken;
  logic [12:0] w_b_imm;

  assign w_is_branch = (instr_q[6:0] == c_opc_branch);
  assign w_funct3    = instr_q[14:12];
  assign w_taken     = w_is_branch &&
                       (((w_funct3 == c_f3_beq) &&  eq) ||
                        ((w_funct3 == c_f3_bne) && !eq));
  assign w_b_imm     = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    imem_req     = 1'b0;
    PCsrc        = 1'b1;        // hold: PC + 0
    ImmOp        = '0;
    instr_valid  = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = !halt;
        if (!halt) begin
          if (imem_ready) begin
            instr_d = instr;
            state_d = ST_EXEC;
          end else if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_EXEC: begin
        instr_valid = 1'b1;
        if (w_taken) begin
          PCsrc = 1'b1;
          ImmOp = {{(WIDTH-13){w_b_imm[12]}}, w_b_imm};
        end else begin
          PCsrc = 1'b0;
        end
        if (retire_cnt_q != {CNT_W{1'b1}}) begin
          retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        state_d = ST_FETCH;
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Reset overrides the datapath controls in the same cycle so a branch
    // pending in EXEC is never applied while the PC is being reset.
    if (rst) begin
      state_d     = ST_RESET;
      imem_req    = 1'b0;
      PCsrc       = 1'b1;
      ImmOp       = '0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      instr_q      <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with a small PC datapath
//            model driven by the DUT's PCsrc/ImmOp and a phase-level
//            reference model of the fetch/execute sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;     // small counters so saturation is reachable
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             halt = 1'b0;
  logic             imem_ready = 1'b0;
  logic [WIDTH-1:0] instr = '0;
  logic             eq = 1'b0;
  logic             imem_req;
  logic             PCsrc;
  logic [WIDTH-1:0] ImmOp;
  logic [WIDTH-1:0] instr_q;
  logic             instr_valid;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .eq          (eq),
    .imem_req    (imem_req),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .instr_q     (instr_q),
    .instr_valid (instr_valid),
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
  );

  // Datapath PC driven by the DUT's controls.
  logic [WIDTH-1:0] dp_pc;
  always @(posedge clk) begin
    if (rst) dp_pc <= '0;
    else     dp_pc <= dp_pc + (PCsrc ? ImmOp : 32'd4);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0=reset, 1=fetch, 2=execute.
  int          m_phase = 0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  int          m_ret   = 0;
  int          m_stall = 0;

  function automatic bit br_taken(input logic [31:0] ins, input bit e);
    int f3;
    if ((ins & 32'h7F) != 32'h63) return 1'b0;
    f3 = int'((ins >> 12) & 32'h7);
    return (f3 == 0 && e) || (f3 == 1 && !e);
  endfunction

  function automatic logic [31:0] b_offset(input logic [31:0] ins);
    int v;
    v = int'((ins >> 8)  & 32'hF)  * 2
      + int'((ins >> 25) & 32'h3F) * 32
      + int'((ins >> 7)  & 32'h1)  * 2048
      + int'((ins >> 31) & 32'h1)  * 4096;
    if (v >= 4096) v = v - 8192;
    return 32'(v);
  endfunction

  // One clock: drive inputs at negedge, compare, then advance the model.
  task automatic cyc(input bit r, input bit h, input bit rdy, input bit e,
                     input logic [31:0] ins);
    bit          x_req, x_src, x_val, tk;
    logic [31:0] x_imm;
    @(negedge clk);
    rst = r; halt = h; imem_ready = rdy; eq = e; instr = ins;
    #1;
    tk    = (m_phase == 2) && br_taken(m_instr, e);
    x_req = 1'b0; x_src = 1'b1; x_imm = '0; x_val = 1'b0;
    if (!r && m_phase == 1) begin
      x_req = !h;
    end else if (!r && m_phase == 2) begin
      x_val = 1'b1;
      x_src = tk;
      x_imm = tk ? b_offset(m_instr) : 32'd0;
    end
    check("imem_req",    64'(imem_req),    64'(x_req));
    check("PCsrc",       64'(PCsrc),       64'(x_src));
    check("ImmOp",       64'(ImmOp),       64'(x_imm));
    check("instr_valid", 64'(instr_valid), 64'(x_val));
    check("instr_q",     64'(instr_q),     64'(m_instr));
    check("retire_cnt",  64'(retire_cnt),  64'(m_ret));
    check("stall_cnt",   64'(stall_cnt),   64'(m_stall));
    check("pc",          64'(dp_pc),       64'(m_pc));
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_pc = '0; m_instr = '0; m_ret = 0; m_stall = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (!h && rdy) begin
            m_instr = ins;
            m_phase = 2;
          end else if (!h && m_stall < CMAX) begin
            m_stall++;
          end
        end
        default: begin
          m_pc    = m_pc + (tk ? b_offset(m_instr) : 32'd4);
          m_ret   = (m_ret < CMAX) ? m_ret + 1 : m_ret;
          m_phase = 1;
        end
      endcase
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = int'($urandom_range(0, 3));
    case (k)
      0: return 32'h0000_0013;
      1: return (r & ~32'h0000_707F) | 32'h63;                 // BEQ
      2: return (r & ~32'h0000_707F) | 32'h63 | 32'h1000;      // BNE
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] c_bne = 32'hFE00_9CE3;   // bne x1,x0,-8

  initial begin
    // Unchecked power-on reset cycle so the DUT flops become known.
    cyc_unchecked();

    // Reset held for two cycles.
    cyc(1, 0, 1, 0, 32'h13);
    cyc(1, 0, 1, 0, 32'h13);

    // Straight line: RESET, then three FETCH/EXEC pairs.
    repeat (7) cyc(0, 0, 1, 0, 32'h13);
    #2;
    check("straight_retire", 64'(retire_cnt), 64'd3);
    check("straight_stall",  64'(stall_cnt),  64'd0);
    check("straight_pc",     64'(dp_pc),      64'd12);

    // BNE taken from PC 12 -> 4.
    cyc(0, 0, 1, 0, c_bne);
    cyc(0, 0, 1, 0, 32'h13);
    #2;
    check("bne_taken_pc", 64'(dp_pc), 64'd4);

    // BNE not taken from PC 4 -> 8.
    cyc(0, 0, 1, 1, c_bne);
    cyc(0, 0, 1, 1, 32'h13);
    #2;
    check("bne_not_taken_pc", 64'(dp_pc), 64'd8);

    // Wait states then halt: PC holds, only the waits count.
    repeat (3) cyc(0, 0, 0, 0, 32'h13);
    repeat (2) cyc(0, 1, 1, 0, 32'h13);
    #2;
    check("wait_stall", 64'(stall_cnt), 64'd3);
    check("wait_pc",    64'(dp_pc),     64'd8);
    cyc(0, 0, 1, 0, 32'h13);
    cyc(0, 1, 1, 0, 32'h13);   // halt during EXEC: instruction still retires
    #2;
    check("halt_exec_retire", 64'(retire_cnt), 64'd6);

    // Reset during EXEC of a taken branch.
    cyc(0, 0, 1, 0, c_bne);
    cyc(1, 0, 1, 0, 32'h13);
    #2;
    check("rst_exec_pc",     64'(dp_pc),       64'd0);
    check("rst_exec_valid",  64'(instr_valid), 64'd0);
    check("rst_exec_retire", 64'(retire_cnt),  64'd0);
    check("rst_exec_stall",  64'(stall_cnt),   64'd0);

    // Saturation of both counters.
    repeat (20) cyc(0, 0, 0, 0, 32'h13);
    #2;
    check("stall_sat", 64'(stall_cnt), 64'(CMAX));
    repeat (40) cyc(0, 0, 1, 0, 32'h13);
    #2;
    check("retire_sat", 64'(retire_cnt), 64'(CMAX));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          rand_instr());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic cyc_unchecked();
    @(negedge clk);
    rst = 1'b1; halt = 1'b0; imem_ready = 1'b0; eq = 1'b0; instr = '0;
    @(posedge clk);
    m_phase = 0; m_pc = '0; m_instr = '0; m_ret = 0; m_stall = 0;
  endtask

endmodule
`default_nettype wire
